// File: rtl/mod_arith_pkg.sv
// Shared types and elaboration helpers for the pipelined modular add/sub datapath.
package mod_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Two extra bits hold both x + y (carry) and x - y (sign) in two's complement.
  function automatic int raw_width(input int w);
    return w + 2;
  endfunction

  function automatic bit params_legal(input int w, input int m);
    return (w >= 1) && (w <= 30) && (m >= 2) && (longint'(m) <= (longint'(1) << w));
  endfunction

endpackage

`define MOD_ARITH_CHECK_PARAMS(w, m) \
  if (!mod_arith_pkg::params_legal((w), (m))) begin : g_illegal_params \
    $error("mod_arith: illegal parameters W=%0d M=%0d", (w), (m)); \
  end

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle between source, pipeline and consumer.
interface mod_addsub_pipe_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic         s;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         err;

  modport master (
    output in_valid, s, x, y, out_ready,
    input  in_ready, out_valid, r, err
  );

  modport slave (
    input  in_valid, s, x, y, out_ready,
    output in_ready, out_valid, r, err
  );
endinterface

// File: rtl/mod_correct.sv
// Stage-2 correction: folds the stage-1 raw sum/difference back into 0..M-1.
module mod_correct
  import mod_arith_pkg::*;
#(
  parameter int W = 4,
  parameter int M = 11
) (
  input  logic signed [raw_width(W)-1:0] raw,
  input  op_e                            s,
  input  logic                           e1,
  output logic        [W-1:0]            r_next,
  output logic                           err_next
);

  localparam int RW = raw_width(W);
  localparam logic signed [RW-1:0] M_RAW = RW'(M);

  logic [W-1:0] r_fix;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    r_fix = W'(raw);
    if (s == OP_ADD) begin
      if (raw >= M_RAW) r_fix = W'(raw - M_RAW);
    end else begin
      if (raw < 0) r_fix = W'(raw + M_RAW);
    end
    r_next   = e1 ? '0 : r_fix;
    err_next = e1;
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/sub pipeline with valid/ready flow control and operand range flag.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int W = 4,
  parameter int M = 11
) (
  input logic              clk,
  input logic              rst_n,
  mod_addsub_pipe_if.slave bus
);

  localparam int RW = raw_width(W);
  localparam logic [W:0] M_EXT = (W+1)'(M);

  `MOD_ARITH_CHECK_PARAMS(W, M)

  logic                 v1, v2;
  logic signed [RW-1:0] raw1;
  op_e                  s1;
  logic                 e1;
  logic        [W-1:0]  r_q;
  logic                 err_q;

  logic                 adv1, adv2;
  logic        [RW-1:0] x_ext, y_ext;
  logic signed [RW-1:0] raw_in;
  logic                 e_in;
  logic        [W-1:0]  r_next;
  logic                 err_next;

  // An empty stage always loads, so bubbles collapse and a full pipe still moves 1/cycle.
  assign adv2 = !v2 || bus.out_ready;
  assign adv1 = !v1 || adv2;

  assign x_ext  = RW'(bus.x);
  assign y_ext  = RW'(bus.y);
  assign raw_in = (op_e'(bus.s) == OP_SUB) ? $signed(x_ext - y_ext) : $signed(x_ext + y_ext);
  assign e_in   = ({1'b0, bus.x} >= M_EXT) || ({1'b0, bus.y} >= M_EXT);

  mod_correct #(
    .W (W),
    .M (M)
  ) u_correct (
    .raw      (raw1),
    .s        (s1),
    .e1       (e1),
    .r_next   (r_next),
    .err_next (err_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, because r and err are visible outputs with defined reset values.
    if (!rst_n) begin
      v1    <= 1'b0;
      raw1  <= '0;
      s1    <= OP_ADD;
      e1    <= 1'b0;
      v2    <= 1'b0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      if (adv1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          raw1 <= raw_in;
          s1   <= op_e'(bus.s);
          e1   <= e_in;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          r_q   <= r_next;
          err_q <= err_next;
        end
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2;
  assign bus.r         = r_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench: W=4/M=11 directed plus W=6/M=37 randomized handshake traffic.
module tb_mod_addsub_pipe;

  localparam int WA = 4;
  localparam int MA = 11;
  localparam int WB = 6;
  localparam int MB = 37;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.W(WA)) ifa ();
  mod_addsub_pipe_if #(.W(WB)) ifb ();

  mod_addsub_pipe #(.W(WA), .M(MA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mod_addsub_pipe #(.W(WB), .M(MB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    int r;
    bit err;
    int acc_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   acc_a = 0;
  bit   lat_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input int r);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got beat r=%0d, want no beat", name, r);
  endtask

  // Reference: plain modular arithmetic on integers, out-of-range operands flagged.
  function automatic exp_t model(input bit sub, input int x, input int y, input int m, input int c);
    exp_t e;
    e.acc_cyc = c;
    if (x >= m || y >= m) begin
      e.r   = 0;
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      e.r   = sub ? ((x - y) % m + m) % m : (x + y) % m;
    end
    return e;
  endfunction

  // Monitor A: pushes on accept, pops/compares on output transfer, checks stall stability.
  logic [WA-1:0] hold_r_a;
  logic          hold_err_a;
  bit            stall_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      qa.delete();
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("A stall out_valid", 32'(ifa.out_valid), 1);
        check("A stall r", 32'(ifa.r), 32'(hold_r_a));
        check("A stall err", 32'(ifa.err), 32'(hold_err_a));
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) spurious("A spurious output", int'(ifa.r));
        else begin
          e = qa.pop_front();
          check("A r", 32'(ifa.r), e.r);
          check("A err", 32'(ifa.err), 32'(e.err));
          if (lat_chk) check("A latency", cyc - e.acc_cyc, 2);
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        qa.push_back(model(ifa.s, int'(ifa.x), int'(ifa.y), MA, cyc));
        acc_a++;
      end
      stall_a    = ifa.out_valid && !ifa.out_ready;
      hold_r_a   = ifa.r;
      hold_err_a = ifa.err;
    end
  end

  logic [WB-1:0] hold_r_b;
  logic          hold_err_b;
  bit            stall_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qb.delete();
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        check("B stall out_valid", 32'(ifb.out_valid), 1);
        check("B stall r", 32'(ifb.r), 32'(hold_r_b));
        check("B stall err", 32'(ifb.err), 32'(hold_err_b));
      end
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) spurious("B spurious output", int'(ifb.r));
        else begin
          e = qb.pop_front();
          check("B r", 32'(ifb.r), e.r);
          check("B err", 32'(ifb.err), 32'(e.err));
        end
      end
      if (ifb.in_valid && ifb.in_ready)
        qb.push_back(model(ifb.s, int'(ifb.x), int'(ifb.y), MB, 0));
      stall_b    = ifb.out_valid && !ifb.out_ready;
      hold_r_b   = ifb.r;
      hold_err_b = ifb.err;
    end
  end

  task automatic send_a(input bit sub, input int x, input int y);
    bit ok;
    ok = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.s        = sub;
    ifa.x        = WA'(x);
    ifa.y        = WA'(y);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ifa.in_ready;
    end
    check("A accept in time", 32'(ok), 1);
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int i;
    i = 0;
    while (qa.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("A drained", qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int i;
    i = 0;
    while (qb.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("B drained", qb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, guard;
    int  a0;
    bit  acc;
    ifa.in_valid = 1'b0; ifa.s = 1'b0; ifa.x = '0; ifa.y = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.s = 1'b0; ifb.x = '0; ifb.y = '0; ifb.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset A out_valid", 32'(ifa.out_valid), 0);
    check("reset A r", 32'(ifa.r), 0);
    check("reset A err", 32'(ifa.err), 0);
    check("reset A in_ready", 32'(ifa.in_ready), 1);
    check("reset B out_valid", 32'(ifb.out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed ops with latency tracking: expect 1, 6, 9, 0.
    ifa.out_ready = 1'b1;
    lat_chk = 1'b1;
    send_a(1'b0, 7, 5);
    send_a(1'b1, 3, 8);
    send_a(1'b0, 10, 10);
    send_a(1'b1, 0, 0);
    drain_a();
    lat_chk = 1'b0;

    // Exhaustive in-range sweep.
    for (int x = 0; x < MA; x++)
      for (int y = 0; y < MA; y++)
        for (int s = 0; s < 2; s++)
          send_a(s[0], x, y);
    drain_a();

    // Out-of-range operand, then a clean op behind it.
    send_a(1'b0, 12, 3);
    send_a(1'b0, 4, 4);
    drain_a();

    // Backpressure: in_valid held high with the consumer stalled for 4 cycles.
    ifa.out_ready = 1'b0;
    a0 = acc_a;
    fork
      begin
        send_a(1'b0, 1, 1);
        send_a(1'b0, 2, 2);
        send_a(1'b0, 3, 3);
      end
    join_none
    repeat (4) @(negedge clk);
    check("stall accepted beats", acc_a - a0, 2);
    check("stall in_ready", 32'(ifa.in_ready), 0);
    check("stall out_valid", 32'(ifa.out_valid), 1);
    check("stall r", 32'(ifa.r), 2);
    @(posedge clk);
    #1 ifa.out_ready = 1'b1;
    wait fork;
    drain_a();

    // Randomized traffic on the W=6, M=37 instance.
    sent  = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      ifb.out_ready = 1'($urandom_range(0, 1));
      if (!ifb.in_valid && $urandom_range(0, 1) == 1) begin
        ifb.in_valid = 1'b1;
        ifb.s        = 1'($urandom_range(0, 1));
        ifb.x        = WB'($urandom_range(0, MB + 2));
        ifb.y        = WB'($urandom_range(0, MB + 2));
      end
      @(negedge clk);
      acc = ifb.in_valid && ifb.in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      if (acc) ifb.in_valid = 1'b0;
      guard++;
    end
    check("B ops issued", sent, 1000);
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    drain_b();
    @(posedge clk);
    #1;

    // Asynchronous reset with two ops in flight.
    ifa.out_ready = 1'b0;
    send_a(1'b0, 1, 2);
    send_a(1'b0, 5, 5);
    check("pre-reset A out_valid", 32'(ifa.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(ifa.out_valid), 0);
    check("async reset r", 32'(ifa.r), 0);
    check("async reset err", 32'(ifa.err), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset in_ready", 32'(ifa.in_ready), 1);
    repeat (6) @(negedge clk);
    check("post-reset out_valid", 32'(ifa.out_valid), 0);
    @(posedge clk);
    #1;
    send_a(1'b1, 2, 3);
    drain_a();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
